// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory arbiter: FSM encoding, owner tags, default priority.
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_REQ  = 3'b010,
        S_RESP = 3'b100
    } arb_state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int DATA_PRIO_DEFAULT = 1;

endpackage

// File: rtl/cpu_mem_arbiter_perf_counter.sv
// Free-running event counter for the perf-counter bank; wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges fetch and data channels onto one memory port, one transaction in flight,
// routing read responses back to the issuing channel.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int DATA_PRIO = DATA_PRIO_DEFAULT,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PC,
    input  logic             Inst_Req_Valid,
    output logic             Inst_Req_Ready,
    output logic [31:0]      Instruction,
    output logic             Inst_Valid,
    input  logic             Inst_Ready,
    input  logic [31:0]      Address,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [31:0]      Write_data,
    input  logic [3:0]       Write_strb,
    output logic             Mem_Req_Ready,
    output logic [31:0]      Read_data,
    output logic             Read_data_Valid,
    input  logic             Read_data_Ready,
    output logic [31:0]      mem_addr,
    output logic             mem_wen,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_rdata_valid,
    output logic             mem_rdata_ready,
    output logic [CNT_W-1:0] inst_txn_cnt,
    output logic [CNT_W-1:0] data_txn_cnt,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic [CNT_W-1:0] stray_cnt
);

    arb_state_t  state_q, state_d;
    logic        owner_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic data_req;
    logic grant_i, grant_d;
    logic in_idle, in_req, in_resp;
    logic resp_hs;

    assign data_req = MemRead | MemWrite;
    assign in_idle  = (state_q == S_IDLE);
    assign in_req   = (state_q == S_REQ);
    assign in_resp  = (state_q == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        mem_req_valid   = 1'b0;
        mem_rdata_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Strays are drained here so a late response can never wedge the port.
                mem_rdata_ready = 1'b1;
                if (data_req && (DATA_PRIO != 0 || !Inst_Req_Valid)) begin
                    grant_d = 1'b1;
                    state_d = S_REQ;
                end else if (Inst_Req_Valid) begin
                    grant_i = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = wen_q ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                mem_rdata_ready = (owner_q == OWNER_D) ? Read_data_Ready : Inst_Ready;
                if (mem_rdata_valid && mem_rdata_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured at grant so the core may move on while the port stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWNER_I;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (grant_d) begin
            owner_q <= OWNER_D;
            wen_q   <= MemWrite;
            addr_q  <= Address;
            wdata_q <= Write_data;
            wstrb_q <= MemWrite ? Write_strb : 4'b0000;
        end else if (grant_i) begin
            owner_q <= OWNER_I;
            wen_q   <= 1'b0;
            addr_q  <= PC;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
        end
    end

    assign Inst_Req_Ready  = grant_i;
    assign Mem_Req_Ready   = grant_d;

    assign mem_addr        = addr_q;
    assign mem_wen         = wen_q;
    assign mem_wdata       = wdata_q;
    assign mem_wstrb       = wstrb_q;

    assign Inst_Valid      = in_resp && (owner_q == OWNER_I) && mem_rdata_valid;
    assign Instruction     = (in_resp && (owner_q == OWNER_I)) ? mem_rdata : '0;
    assign Read_data_Valid = in_resp && (owner_q == OWNER_D) && mem_rdata_valid;
    assign Read_data       = (in_resp && (owner_q == OWNER_D)) ? mem_rdata : '0;

    assign resp_hs = in_resp && mem_rdata_valid && mem_rdata_ready;

    logic inst_done, data_done, conflict_seen, stray_seen;

    // Stores complete at the request handshake, loads at the response handshake.
    assign inst_done     = resp_hs && (owner_q == OWNER_I);
    assign data_done     = (resp_hs && (owner_q == OWNER_D)) || (in_req && wen_q && mem_req_ready);
    assign conflict_seen = in_idle && Inst_Req_Valid && data_req;
    assign stray_seen    = in_idle && mem_rdata_valid;

    perf_counter #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk(clk), .rst(rst), .inc(inst_done), .value(inst_txn_cnt)
    );
    perf_counter #(.CNT_W(CNT_W)) u_data_cnt (
        .clk(clk), .rst(rst), .inc(data_done), .value(data_txn_cnt)
    );
    perf_counter #(.CNT_W(CNT_W)) u_conf_cnt (
        .clk(clk), .rst(rst), .inc(conflict_seen), .value(conflict_cnt)
    );
    perf_counter #(.CNT_W(CNT_W)) u_stray_cnt (
        .clk(clk), .rst(rst), .inc(stray_seen), .value(stray_cnt)
    );

endmodule
